// File: rtl/led_panel_pkg.sv
// Shared constants, state encoding and command table for the
// HT1632C-style LED panel serial transmitter.
package led_panel_pkg;

  localparam int ROWS       = 16;
  localparam int COLS       = 24;
  localparam int FRAME_BITS = 394;

  localparam logic [2:0] ID_CMD = 3'b100;
  localparam logic [2:0] ID_WR  = 3'b101;

  localparam logic [7:0] SYS_EN    = 8'h01;
  localparam logic [7:0] COM_OPT   = 8'h24;
  localparam logic [7:0] BLINK_OFF = 8'h08;
  localparam logic [7:0] PWM_16    = 8'hAF;
  localparam logic [7:0] LED_ON    = 8'h03;

  localparam int NCMD     = 5;
  localparam int CMD_BITS = 12;

  typedef enum logic [2:0] {
    S_INIT_LOAD,
    S_INIT_SHIFT,
    S_INIT_GAP,
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_e;

  // Command word is ID, command byte, then one don't-care bit.
  function automatic logic [CMD_BITS-1:0] cmd_word(
    input logic [2:0] idx
  );
    logic [7:0] c;
    case (idx)
      3'd0:    c = SYS_EN;
      3'd1:    c = COM_OPT;
      3'd2:    c = BLINK_OFF;
      3'd3:    c = PWM_16;
      default: c = LED_ON;
    endcase
    return {ID_CMD, c, 1'b0};
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Phase timer: write-low/write-high half periods while shifting,
// and a single CS_GAP countdown between transactions.
module led_bit_timer
  import led_panel_pkg::*;
#(
  parameter int HALF_DIV = 25,
  parameter int CS_GAP   = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic gap_i,
  input  logic run_i,
  output logic tick_o,
  output logic hi_o
);

  localparam int MAXC = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
  localparam int PW   = $clog2(MAXC + 1);

  logic [PW-1:0] ph_q;
  logic          hi_q;

  // Counts down to zero and holds there unless a bit is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q <= '0;
      hi_q <= 1'b0;
    end else if (start_i) begin
      ph_q <= PW'(HALF_DIV - 1);
      hi_q <= 1'b0;
    end else if (gap_i) begin
      ph_q <= PW'(CS_GAP - 1);
      hi_q <= 1'b0;
    end else if (ph_q != '0) begin
      ph_q <= ph_q - PW'(1);
    end else if (run_i) begin
      ph_q <= PW'(HALF_DIV - 1);
      hi_q <= ~hi_q;
    end
  end

  assign tick_o = (ph_q == '0);
  assign hi_o   = hi_q;

endmodule

// File: rtl/led_frame_tx.sv
// Serial transmit stage to the LED panel: init command list after
// reset, then valid/ready framed transfers on cs/write/data.
module led_frame_tx
  import led_panel_pkg::*;
#(
  parameter int MAX_BITS = 394,
  parameter int NBITS_W  = 9,
  parameter int HALF_DIV = 25,
  parameter int CS_GAP   = 50
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [MAX_BITS-1:0] frame_in,
  input  logic [NBITS_W-1:0]  frame_nbits,
  input  logic                frame_valid,
  output logic                frame_ready,
  output logic                frame_done,
  output logic                busy,
  output logic                cs,
  output logic                write,
  output logic                data
);

  state_e                state_q;
  logic [MAX_BITS-1:0]   sh_q;
  logic [NBITS_W-1:0]    cnt_q;
  logic [2:0]            cmd_idx_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  cs_q;
  logic                  wr_q;
  logic                  data_q;

  logic                  shifting;
  logic                  tick;
  logic                  hi;
  logic                  start;
  logic                  gap_ld;
  logic [NBITS_W-1:0]    n_clamp;
  logic [NBITS_W-1:0]    sh_amt;
  logic [CMD_BITS-1:0]   cmd_w;

  assign shifting = (state_q == S_SHIFT) || (state_q == S_INIT_SHIFT);
  assign start    = (state_q == S_INIT_LOAD) ||
                    ((state_q == S_LOAD) && (cnt_q != '0));
  assign gap_ld   = shifting && tick && hi && (cnt_q == '0);

  assign n_clamp = (frame_nbits > NBITS_W'(MAX_BITS)) ?
                   NBITS_W'(MAX_BITS) : frame_nbits;
  assign sh_amt  = NBITS_W'(MAX_BITS) - n_clamp;
  assign cmd_w   = cmd_word(cmd_idx_q);

  led_bit_timer #(
    .HALF_DIV (HALF_DIV),
    .CS_GAP   (CS_GAP)
  ) u_timer (
    .clk     (clk),
    .rst     (RST),
    .start_i (start),
    .gap_i   (gap_ld),
    .run_i   (shifting),
    .tick_o  (tick),
    .hi_o    (hi)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= S_INIT_LOAD;
      sh_q      <= '0;
      cnt_q     <= '0;
      cmd_idx_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      cs_q      <= 1'b1;
      wr_q      <= 1'b1;
      data_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_INIT_LOAD: begin
          cs_q    <= 1'b0;
          wr_q    <= 1'b0;
          data_q  <= cmd_w[CMD_BITS-1];
          sh_q    <= {cmd_w[CMD_BITS-2:0],
                      {(MAX_BITS-CMD_BITS+1){1'b0}}};
          cnt_q   <= NBITS_W'(CMD_BITS - 1);
          state_q <= S_INIT_SHIFT;
        end
        S_INIT_SHIFT, S_SHIFT: begin
          if (tick) begin
            if (!hi) begin
              wr_q <= 1'b1;
            end else if (cnt_q != '0) begin
              wr_q   <= 1'b0;
              data_q <= sh_q[MAX_BITS-1];
              sh_q   <= sh_q << 1;
              cnt_q  <= cnt_q - NBITS_W'(1);
            end else begin
              cs_q    <= 1'b1;
              state_q <= (state_q == S_SHIFT) ? S_GAP : S_INIT_GAP;
            end
          end
        end
        S_INIT_GAP: begin
          if (tick) begin
            if (cmd_idx_q == 3'(NCMD - 1)) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              cmd_idx_q <= cmd_idx_q + 3'd1;
              state_q   <= S_INIT_LOAD;
            end
          end
        end
        S_IDLE: begin
          ready_q <= 1'b1;
          if (frame_valid && ready_q) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            sh_q    <= frame_in << sh_amt;
            cnt_q   <= n_clamp;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          // An empty frame completes without touching the panel.
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= sh_q[MAX_BITS-1];
            sh_q    <= sh_q << 1;
            cnt_q   <= cnt_q - NBITS_W'(1);
            state_q <= S_SHIFT;
          end
        end
        S_GAP: begin
          if (tick) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_INIT_LOAD;
      endcase
    end
  end

  assign frame_ready = ready_q;
  assign frame_done  = done_q;
  assign busy        = busy_q;
  assign cs          = cs_q;
  assign write       = wr_q;
  assign data        = data_q;

endmodule

// File: tb/tb_led_frame_tx.sv
// Directed bench for led_frame_tx with short phase timing:
// init list, framed transfers, clamp, empty frame, hold, reset.
module tb_led_frame_tx;

  localparam int MB = 394;
  localparam int NW = 9;
  localparam int HD = 2;
  localparam int CG = 3;

  logic          clk = 1'b0;
  logic          RST;
  logic [MB-1:0] frame_in;
  logic [NW-1:0] frame_nbits;
  logic          frame_valid;
  logic          frame_ready;
  logic          frame_done;
  logic          busy;
  logic          cs;
  logic          write;
  logic          data;

  always #5 clk = ~clk;

  led_frame_tx #(
    .MAX_BITS (MB),
    .NBITS_W  (NW),
    .HALF_DIV (HD),
    .CS_GAP   (CG)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .frame_in    (frame_in),
    .frame_nbits (frame_nbits),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_done  (frame_done),
    .busy        (busy),
    .cs          (cs),
    .write       (write),
    .data        (data)
  );

  int errors = 0;
  int checks = 0;

  int   rises, cslow, dones, accepts, cur_len;
  logic bits[$];
  int   wins[$];
  logic pw = 1'b1;
  logic pc = 1'b1;

  always @(negedge clk) begin
    if (write && !pw) begin
      bits.push_back(data);
      rises++;
      cur_len++;
    end
    if (!cs) cslow++;
    if (cs && !pc) begin
      wins.push_back(cur_len);
      cur_len = 0;
    end
    if (frame_done) dones++;
    if (frame_valid && frame_ready) accepts++;
    pw = write;
    pc = cs;
  end

  task automatic clear_mon();
    bits.delete();
    wins.delete();
    rises = 0; cslow = 0; dones = 0;
    accepts = 0; cur_len = 0;
    pw = write;
    pc = cs;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (frame_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(name, int'(ok), 1);
  endtask

  // Init list: 5 windows of 12 bits, words built from the command table.
  task automatic check_init(input string tag);
    logic [7:0]  cb [5];
    logic [11:0] w;
    logic [11:0] first12;
    int          mism;
    cb = '{8'h01, 8'h24, 8'h08, 8'hAF, 8'h03};
    first12 = 12'b1000_0000_0010;
    mism = 0;
    for (int c = 0; c < 5; c++) begin
      w = {3'b100, cb[c], 1'b0};
      for (int b = 0; b < 12; b++)
        if (bits.size() > c*12 + b)
          if (bits[c*12+b] !== w[11-b]) mism++;
    end
    for (int b = 0; b < 12; b++)
      if (bits.size() > b)
        if (bits[b] !== first12[11-b]) mism++;
    chk({tag, "_nbits"}, bits.size(), 60);
    chk({tag, "_bits"}, mism, 0);
    chk({tag, "_wins"}, wins.size(), 5);
    chk({tag, "_win0"}, wins.size() > 0 ? wins[0] : -1, 12);
    chk({tag, "_win4"}, wins.size() > 4 ? wins[4] : -1, 12);
    chk({tag, "_cslow"}, cslow, 5 * 12 * 2 * HD);
    chk({tag, "_nodone"}, dones, 0);
  endtask

  typedef struct {
    logic [NW-1:0] nbits;
    logic [MB-1:0] frame;
    int            exp_bits;
    int            exp_cslow;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [MB-1:0] pat;
    logic [MB-1:0] fa;
    logic [MB-1:0] fb;
    int            mism;

    for (int i = 0; i < MB; i++) pat[i] = ((i % 3) == 0);
    vecs[0] = '{9'd10,  {{(MB-10){1'b0}}, 10'b1010000000}, 10, 40};
    vecs[1] = '{9'd394, {197{2'b01}}, 394, 1576};
    vecs[2] = '{9'd500, pat, 394, 1576};
    vecs[3] = '{9'd0,   {MB{1'b1}}, 0, 0};
    vecs[4] = '{9'd1,   {{(MB-1){1'b0}}, 1'b1}, 1, 4};
    vecs[5] = '{9'd12,  {{(MB-12){1'b1}}, 12'h35C}, 12, 48};

    RST = 1'b1;
    frame_in = '0;
    frame_nbits = '0;
    frame_valid = 1'b0;
    #12;
    chk("rst_cs", cs, 1);
    chk("rst_write", write, 1);
    chk("rst_data", data, 0);
    chk("rst_ready", frame_ready, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_busy", busy, 1);

    @(negedge clk);
    clear_mon();
    RST = 1'b0;
    wait_ready("init_ready", 2000);
    check_init("init");
    chk("init_busy", busy, 0);

    for (int v = 0; v < 6; v++) begin
      wait_ready("vec_ready", 4000);
      clear_mon();
      frame_in = vecs[v].frame;
      frame_nbits = vecs[v].nbits;
      frame_valid = 1'b1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      frame_in = ~vecs[v].frame;
      frame_nbits = '1;
      chk("acc_busy", busy, 1);
      chk("acc_cs", cs, 1);
      @(posedge clk); #1;
      chk("cs_lat", cs, vecs[v].exp_bits == 0 ? 1 : 0);
      chk("done_lat", frame_done, vecs[v].exp_bits == 0 ? 1 : 0);
      wait_ready("vec_end", 4000);
      mism = 0;
      for (int k = 0; k < vecs[v].exp_bits; k++)
        if (k < bits.size())
          if (bits[k] !== vecs[v].frame[vecs[v].exp_bits-1-k]) mism++;
      chk("vec_rises", rises, vecs[v].exp_bits);
      chk("vec_bits", mism, 0);
      chk("vec_cslow", cslow, vecs[v].exp_cslow);
      chk("vec_done", dones, 1);
      chk("vec_acc", accepts, 1);
      chk("vec_wins", wins.size(), vecs[v].exp_bits == 0 ? 0 : 1);
    end

    // Second frame held valid while the first is still shifting.
    fa = {{(MB-10){1'b0}}, 10'b1100101001};
    fb = {{(MB-12){1'b1}}, 12'hA3C};
    wait_ready("hold_ready", 4000);
    clear_mon();
    frame_in = fa;
    frame_nbits = 9'd10;
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_in = fb;
    frame_nbits = 9'd12;
    repeat (20) @(posedge clk);
    #1;
    chk("hold_ready_low", frame_ready, 0);
    chk("hold_busy", busy, 1);
    chk("hold_acc1", accepts, 1);
    wait_ready("hold_idle", 4000);
    @(posedge clk); #1;
    frame_valid = 1'b0;
    wait_ready("hold_end", 4000);
    mism = 0;
    for (int k = 0; k < 10; k++)
      if (k < bits.size())
        if (bits[k] !== fa[9-k]) mism++;
    for (int k = 0; k < 12; k++)
      if (10 + k < bits.size())
        if (bits[10+k] !== fb[11-k]) mism++;
    chk("hold_wins", wins.size(), 2);
    chk("hold_win0", wins.size() > 0 ? wins[0] : -1, 10);
    chk("hold_win1", wins.size() > 1 ? wins[1] : -1, 12);
    chk("hold_bits", mism, 0);
    chk("hold_done", dones, 2);
    chk("hold_acc2", accepts, 2);

    // Reset in the middle of a full frame.
    wait_ready("rst_ready_w", 4000);
    clear_mon();
    frame_in = vecs[1].frame;
    frame_nbits = 9'd394;
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (rises >= 100) break;
      @(negedge clk);
    end
    chk("mid_rises", rises, 100);
    chk("mid_cs_low", cs, 0);
    #1;
    RST = 1'b1;
    #1;
    chk("mid_rst_cs", cs, 1);
    chk("mid_rst_write", write, 1);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ready", frame_ready, 0);
    @(negedge clk);
    clear_mon();
    @(negedge clk);
    RST = 1'b0;
    wait_ready("rinit_ready", 2000);
    check_init("rinit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
